divisor_seq: RTL and testbench
==============================

Name: divisor_seq

Overview:
Sequential restoring divider: 2N-bit unsigned dividend by N-bit unsigned divisor, giving an N-bit quotient and an N-bit remainder.
It is the inverse companion of the shift-add multiplicador, with the same St/Done/Idle control handshake.
Datapath: one (2N+1)-bit shift accumulator, a divisor register, a compare/subtract unit, an iteration counter and a small control FSM.
Instantiated next to multiplicador in the MIPS datapath for DIVU.

Parameters:
N, 16, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
Clk  input  1  clock, rising edge.
Rst_n  input  1  asynchronous reset, active-low.
St  input  1  start request; sampled only while Idle=1.
Dividendo  input  2N  dividend; captured on the accepting edge.
Divisor  input  N  divisor; captured on the accepting edge.
Quociente  output  N  registered quotient; holds until the next accepted St.
Resto  output  N  registered remainder; holds until the next accepted St.
Ovf  output  1  registered; 1 = divide-by-zero or quotient wider than N bits.
Done  output  1  one-cycle pulse marking result valid.
Idle  output  1  1 when the FSM is in IDLE.

Behaviour:
- Reset (Rst_n=0, asynchronous): FSM→IDLE; ACC, divisor register and counter cleared. Outputs: Quociente=0, Resto=0, Ovf=0, Done=0, Idle=1. Reset mid-operation aborts with no Done.
- FSM states and transitions:
  - IDLE: Idle=1. On St=1: ACC←{1'b0,Dividendo}, DReg←Divisor, counter←0, Quociente/Resto/Ovf←0, go to CHECK. St=0 stays in IDLE.
  - CHECK (1 cycle): if ACC[2N-1:N] >= DReg (includes DReg=0): Ovf←1, go to DONE. Otherwise go to DIV.
  - DIV (exactly N cycles): each cycle T = ACC<<1.
    - If T[2N:N] >= {1'b0,DReg}: ACC←{T[2N:N]-DReg, T[N-1:1], 1'b1}.
    - Else ACC←T.
    - Counter increments; on the cycle counter=N-1 (K=1), Quociente←new ACC[N-1:0] and Resto←new ACC[2N-1:N], then go to DONE.
  - DONE (1 cycle): Done=1, Idle=0, then go to IDLE.
- Latency, with St accepted at edge 0:
  - Normal: CHECK in cycle 1, DIV in cycles 2..N+1, Done=1 in cycle N+2 (cycle 18 for N=16). Idle returns in cycle N+3.
  - Overflow: Done=1 in cycle 2; Quociente=Resto=0.
- St while Idle=0: ignored. St held high continuously: a new operation is accepted in the first IDLE cycle.
- Dividendo/Divisor changes after the accepting edge have no effect.
- Arithmetic is unsigned only. The subtract is N+1 bits wide, so the shifted-out MSB participates in the compare.
- Invariant on a non-overflow result: Quociente*Divisor + Resto == Dividendo, and Resto < Divisor.

Decomposition:
- Shared package: default N; FSM state encodings IDLE/CHECK/DIV/DONE (2 bits); counter width localparam $clog2(N)+1.
- One sub-module: subtrator_cmp. Combinational (N+1)-bit compare-and-subtract with outputs Dif[N:0] and Ge.
- Counter and FSM stay in divisor_seq.

Test Plan:
- Reset then 100/7 -> Quociente=14, Resto=2, Ovf=0, Done pulse exactly in cycle 18, Idle=1 in cycle 19.
- 0xFFFE0001/0xFFFF -> Quociente=0xFFFF, Resto=0, Ovf=0.
- 0x12345678/0 -> Ovf=1, Quociente=0, Resto=0, Done in cycle 2. Also 0x00070000/7 -> Ovf=1 (upper half equals divisor).
- Start 1000/3; pulse St with different operands in cycles 5 and 10 -> ignored, result Quociente=333, Resto=1.
- Start 50000/9; assert Rst_n=0 in cycle 8 -> outputs zero immediately, Idle=1, no Done. Then 50000/9 -> Quociente=5555, Resto=5.
- Random 500 unsigned pairs with St held high back-to-back -> every Done satisfies Quociente*Divisor+Resto==Dividendo and Resto<Divisor, or Ovf is set correctly.

Source files
------------

// File: rtl/divisor_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM encodings and the iteration counter sizing.
package divisor_seq_pkg;

  localparam int N_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One extra bit so the counter can hold N itself without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CNT_W = cnt_width(N_DEF);

endpackage

// File: rtl/divisor_seq_subtrator_cmp.sv
// Combinational (N+1)-bit compare-and-subtract used by the divider for both
// the overflow pre-check and every restoring step.
module subtrator_cmp
  import divisor_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0] A,
  input  logic [N:0] B,
  output logic [N:0] Dif,
  output logic       Ge
);

  logic borrow;

  // A single subtractor yields both the difference and, via its borrow, A >= B.
  assign {borrow, Dif} = {1'b0, A} - {1'b0, B};
  assign Ge = ~borrow;

endmodule

// File: rtl/divisor_seq.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, producing an
// N-bit quotient and remainder with the St/Done/Idle handshake of multiplicador.
module divisor_seq
  import divisor_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           St,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quociente,
  output logic [N-1:0]   Resto,
  output logic           Ovf,
  output logic           Done,
  output logic           Idle
);

  localparam int CntW = cnt_width(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_t          state_q;
  logic [2*N:0]    acc_q;
  logic [2*N:0]    acc_d;
  logic [2*N:0]    shifted;
  logic [N-1:0]    divReg_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    quo_q;
  logic [N-1:0]    res_q;
  logic            ovf_q;
  logic            done_q;
  logic            idle_q;
  logic [N:0]      cmpA;
  logic [N:0]      dif;
  logic            ge;

  // The comparator is shared: in CHECK it sees the raw upper half, in DIV the
  // shifted partial remainder including the bit just shifted out.
  always_comb begin
    shifted = acc_q << 1;
    cmpA    = (state_q == CHECK) ? {1'b0, acc_q[2*N-1:N]} : shifted[2*N:N];
    acc_d   = ge ? {dif, shifted[N-1:1], 1'b1} : shifted;
  end

  subtrator_cmp #(.N(N)) uCmp (
    .A   (cmpA),
    .B   ({1'b0, divReg_q}),
    .Dif (dif),
    .Ge  (ge)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      divReg_q <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (St) begin
            acc_q    <= {1'b0, Dividendo};
            divReg_q <= Divisor;
            cnt_q    <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            idle_q   <= 1'b0;
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          // Upper half >= divisor (or divisor zero) means the quotient cannot fit.
          if (ge) begin
            ovf_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= DIV;
          end
        end
        DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            quo_q   <= acc_d[N-1:0];
            res_q   <= acc_d[2*N-1:N];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Quociente = quo_q;
  assign Resto     = res_q;
  assign Ovf       = ovf_q;
  assign Done      = done_q;
  assign Idle      = idle_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed and back-to-back checks for divisor_seq (N=16) against
// hand-computed quotients, remainders, overflow flags and Done timing.
module tb_divisor_seq;

  logic        Clk;
  logic        Rst_n;
  logic        St;
  logic [31:0] Dividendo;
  logic [15:0] Divisor;
  logic [15:0] Quociente;
  logic [15:0] Resto;
  logic        Ovf;
  logic        Done;
  logic        Idle;

  int checks   = 0;
  int failures = 0;

  divisor_seq #(.N(16)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .Ovf       (Ovf),
    .Done      (Done),
    .Idle      (Idle)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drives St for exactly one accepting edge (edge 0), then scrambles operands.
  task automatic startOp(input logic [31:0] dvd, input logic [15:0] dvs);
    @(negedge Clk);
    Dividendo = dvd;
    Divisor   = dvs;
    St        = 1'b1;
    @(posedge Clk);
    #1;
    St        = 1'b0;
    Dividendo = 32'hDEAD_BEEF;
    Divisor   = 16'h0001;
  endtask

  task automatic runOp(input logic [31:0] dvd, input logic [15:0] dvs,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic ovf, output int doneCyc);
    startOp(dvd, dvs);
    doneCyc = -1;
    q = 'x;
    r = 'x;
    ovf = 1'bx;
    for (int c = 1; c <= 40 && doneCyc < 0; c++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        doneCyc = c;
        q = Quociente;
        r = Resto;
        ovf = Ovf;
      end
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    St = 1'b0;
    Dividendo = '0;
    Divisor = '0;
    #12;
    checks++;
    if ({Quociente, Resto, Ovf, Done, Idle} !== {16'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_outputs got q=%0h r=%0h ovf=%b done=%b idle=%b want 0/0/0/0/1",
               Quociente, Resto, Ovf, Done, Idle);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Done, Idle} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reset_release got done=%b idle=%b want 0/1", Done, Idle);
    end
  endtask

  task automatic test_basic;
    int doneCount = 0;
    int doneCyc = -1;
    startOp(32'd100, 16'd7);
    for (int c = 1; c <= 22; c++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (c == 18) begin
        checks++;
        if (Idle !== 1'b0) begin
          failures++;
          $display("[TB] FAIL basic_idle_c18 got=%b want=0", Idle);
        end
      end
      if (c == 19) begin
        checks++;
        if (Idle !== 1'b1) begin
          failures++;
          $display("[TB] FAIL basic_idle_c19 got=%b want=1", Idle);
        end
      end
    end
    checks++;
    if (doneCount != 1 || doneCyc != 18) begin
      failures++;
      $display("[TB] FAIL basic_done got count=%0d cycle=%0d want count=1 cycle=18", doneCount, doneCyc);
    end
    checks++;
    if ({Quociente, Resto, Ovf} !== {16'd14, 16'd2, 1'b0}) begin
      failures++;
      $display("[TB] FAIL basic_100_7 got q=%0d r=%0d ovf=%b want 14/2/0", Quociente, Resto, Ovf);
    end
  endtask

  task automatic test_max;
    logic [15:0] q, r;
    logic ovf;
    int cyc;
    runOp(32'hFFFE_0001, 16'hFFFF, q, r, ovf, cyc);
    checks++;
    if ({q, r, ovf} !== {16'hFFFF, 16'h0000, 1'b0} || cyc != 18) begin
      failures++;
      $display("[TB] FAIL max_fffe0001 got q=%0h r=%0h ovf=%b cyc=%0d want ffff/0/0/18", q, r, ovf, cyc);
    end
    @(negedge Clk);
    checks++;
    if ({Quociente, Resto, Idle} !== {16'hFFFF, 16'h0000, 1'b1}) begin
      failures++;
      $display("[TB] FAIL max_hold got q=%0h r=%0h idle=%b want ffff/0/1", Quociente, Resto, Idle);
    end
    // Upper half one below the divisor: largest non-overflow quotient.
    runOp(32'h0006_FFFF, 16'd7, q, r, ovf, cyc);
    checks++;
    if ({q, r, ovf} !== {16'hFFFF, 16'd6, 1'b0} || cyc != 18) begin
      failures++;
      $display("[TB] FAIL max_6ffff_7 got q=%0h r=%0d ovf=%b cyc=%0d want ffff/6/0/18", q, r, ovf, cyc);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] q, r;
    logic ovf;
    int cyc;
    runOp(32'h1234_5678, 16'd0, q, r, ovf, cyc);
    checks++;
    if ({q, r, ovf} !== {16'd0, 16'd0, 1'b1} || cyc != 2) begin
      failures++;
      $display("[TB] FAIL ovf_div0 got q=%0h r=%0h ovf=%b cyc=%0d want 0/0/1/2", q, r, ovf, cyc);
    end
    runOp(32'h0007_0000, 16'd7, q, r, ovf, cyc);
    checks++;
    if ({q, r, ovf} !== {16'd0, 16'd0, 1'b1} || cyc != 2) begin
      failures++;
      $display("[TB] FAIL ovf_upper_eq got q=%0h r=%0h ovf=%b cyc=%0d want 0/0/1/2", q, r, ovf, cyc);
    end
  endtask

  task automatic test_ignore_st;
    int doneCount = 0;
    int doneCyc = -1;
    startOp(32'd1000, 16'd3);
    for (int c = 1; c <= 22; c++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (c == 5 || c == 10) begin
        Dividendo = 32'd77777;
        Divisor   = 16'd5;
        St        = 1'b1;
      end else begin
        St = 1'b0;
      end
    end
    St = 1'b0;
    checks++;
    if (doneCount != 1 || doneCyc != 18) begin
      failures++;
      $display("[TB] FAIL ignore_done got count=%0d cycle=%0d want count=1 cycle=18", doneCount, doneCyc);
    end
    checks++;
    if ({Quociente, Resto, Ovf} !== {16'd333, 16'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL ignore_1000_3 got q=%0d r=%0d ovf=%b want 333/1/0", Quociente, Resto, Ovf);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] q, r;
    logic ovf;
    int cyc;
    int doneCount = 0;
    startOp(32'd50000, 16'd9);
    repeat (8) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Quociente, Resto, Ovf, Done, Idle} !== {16'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got q=%0h r=%0h ovf=%b done=%b idle=%b want 0/0/0/0/1",
               Quociente, Resto, Ovf, Done, Idle);
    end
    repeat (3) begin
      @(negedge Clk);
      if (Done === 1'b1) doneCount++;
    end
    Rst_n = 1'b1;
    repeat (20) begin
      @(negedge Clk);
      if (Done === 1'b1) doneCount++;
    end
    checks++;
    if (doneCount != 0 || Idle !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_nodone got dones=%0d idle=%b want 0/1", doneCount, Idle);
    end
    runOp(32'd50000, 16'd9, q, r, ovf, cyc);
    checks++;
    if ({q, r, ovf} !== {16'd5555, 16'd5, 1'b0} || cyc != 18) begin
      failures++;
      $display("[TB] FAIL midreset_rerun got q=%0d r=%0d ovf=%b cyc=%0d want 5555/5/0/18", q, r, ovf, cyc);
    end
  endtask

  task automatic pickOperands(input int i, output logic [31:0] dvd, output logic [15:0] dvs);
    dvs = 16'($urandom_range(0, 65535));
    dvd = $urandom;
    if (i % 25 == 0) begin
      dvs = 16'd0;
    end else if (i % 2 == 0 && dvs != 16'd0) begin
      dvd[31:16] = dvd[31:16] % dvs;
    end
  endtask

  // St stays high so each operation starts in the single IDLE cycle after Done.
  task automatic test_back_to_back;
    logic [31:0] dvd, expDvd, tmp;
    logic [15:0] dvs, expDvs, expQ, expR;
    logic expOvf;
    int gap, wantGap;
    bit got;
    pickOperands(0, dvd, dvs);
    @(negedge Clk);
    Dividendo = dvd;
    Divisor   = dvs;
    St        = 1'b1;
    expDvd    = dvd;
    expDvs    = dvs;
    for (int i = 0; i < 500; i++) begin
      gap = 0;
      got = 0;
      while (!got && gap < 40) begin
        @(negedge Clk);
        gap++;
        if (Done === 1'b1) got = 1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("[TB] FAIL b2b_timeout op=%0d got no Done within 40 cycles want Done", i);
        break;
      end
      expOvf = (expDvs == 16'd0) || (expDvd[31:16] >= expDvs);
      if (expOvf) begin
        expQ = 16'd0;
        expR = 16'd0;
      end else begin
        tmp  = expDvd / {16'd0, expDvs};
        expQ = tmp[15:0];
        tmp  = expDvd % {16'd0, expDvs};
        expR = tmp[15:0];
      end
      checks++;
      if ({Quociente, Resto, Ovf} !== {expQ, expR, expOvf}) begin
        failures++;
        $display("[TB] FAIL b2b_result op=%0d %0h/%0h got q=%0h r=%0h ovf=%b want q=%0h r=%0h ovf=%b",
                 i, expDvd, expDvs, Quociente, Resto, Ovf, expQ, expR, expOvf);
      end
      wantGap = (i == 0) ? (expOvf ? 2 : 18) : (expOvf ? 3 : 19);
      checks++;
      if (gap != wantGap) begin
        failures++;
        $display("[TB] FAIL b2b_latency op=%0d got=%0d want=%0d", i, gap, wantGap);
      end
      pickOperands(i + 1, dvd, dvs);
      Dividendo = dvd;
      Divisor   = dvs;
      expDvd    = dvd;
      expDvs    = dvs;
    end
    St = 1'b0;
  endtask

  initial begin
    $display("[TB] divisor_seq bench start");
    test_reset();
    test_basic();
    test_max();
    test_overflow();
    test_ignore_st();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
